i2c_cmd_seq: RTL and testbench
==============================

// Module: i2c_cmd_seq
// PURPOSE
//  Command sequencer that sits directly upstream of the I2C master.
//  Buffers I2C transactions {addr, rw, mem_addr, wdata} from a valid/ready command port in a FIFO.
//  Issues them to the master one at a time, pulsing en and tracking busy.
//  Returns one response {rdata, ack_err, timeout} per command on a valid/ready response port.
// PARAMETERS
//  FIFO_DEPTH  4   command FIFO entries; power of two, >=2
//  TIMEOUT     16  clk cycles in ISSUE without m_busy rising before abort; >=2
// PORTS
//  clk           in   1  system clock; also the master's clk
//  rst           in   1  reset, asynchronous, active-low
//  cmd_valid     in   1  command present
//  cmd_ready     out  1  FIFO can accept (= !full)
//  cmd_addr      in   7  I2C slave address
//  cmd_rw        in   1  1 = write (master DATA_WR path), 0 = read
//  cmd_mem_addr  in   5  slave register address
//  cmd_wdata     in   8  write data; ignored for reads
//  rsp_valid     out  1  response present
//  rsp_ready     in   1  response consumed
//  rsp_rdata     out  8  read data; 8'h00 for writes and timeouts
//  rsp_ack_err   out  1  master ack_err sampled at end of transaction
//  rsp_timeout   out  1  master never went busy
//  m_en          out  1  to master en
//  m_addr        out  7  to master addr
//  m_rw          out  1  to master rw
//  m_mem_addr    out  5  to master mem_addr
//  m_data_wr     out  8  to master data_wr
//  m_data_rd     in   8  from master data_rd
//  m_ack_err     in   1  from master ack_err
//  m_busy        in   1  from master busy
//  fifo_level    out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  idle          out  1  FIFO empty, FSM in IDLE, and rsp_valid low
// BEHAVIOUR
//  Reset values (all asynchronous)
//   - Outputs: 0, except cmd_ready=1 and idle=1.
//   - FIFO pointers 0; FSM in IDLE.
//  FIFO
//   - Push on cmd_valid && cmd_ready.
//   - Pop only on the FSM pop event (see states below); first-word-fall-through head.
//   - Push and pop in the same cycle: level unchanged.
//   - When full, cmd_ready=0 even if a pop occurs that cycle.
//   - Pointers wrap modulo FIFO_DEPTH.
//  FSM states: IDLE, ISSUE, WAIT, RESP
//  IDLE
//   - If FIFO not empty and m_busy=0: register the head into m_* and go to ISSUE.
//   - m_* hold their last value when not in ISSUE or WAIT.
//  ISSUE
//   - m_en=1 and m_* stable; timeout counter increments each cycle.
//   - m_busy=1: pop FIFO, clear counter, go to WAIT. m_en drops on the next cycle.
//   - Counter reaches TIMEOUT-1 with m_busy still 0: pop FIFO, load response
//     {rdata=0, ack_err=0, timeout=1}, go to RESP.
//  WAIT
//   - m_en=0, which prevents the master restarting after STOP.
//   - On m_busy=0: load rsp_rdata = m_rw ? 8'h00 : m_data_rd, rsp_ack_err = m_ack_err,
//     rsp_timeout=0; go to RESP.
//  RESP
//   - rsp_valid=1 and response fields stable until rsp_ready.
//   - On rsp_ready: rsp_valid drops next cycle; go to IDLE.
//   - A new issue requires a cycle in IDLE, so there is 1 dead cycle between transactions.
//  Latency
//   - Command accepted in an idle system: m_en rises 2 cycles after the push (FIFO write, then IDLE->ISSUE).
//  Ordering and reset
//   - Responses come back strictly in command order; at most one transaction is outstanding.
//   - Reset mid-transaction: FIFO flushed, m_en=0 immediately, any pending response lost.
// STRUCTURE
//  Shared package i2c_pkg
//   - Width constants: ADDR_W=7, MEM_W=5, DATA_W=8, CMD_W=21.
//   - Command field offsets.
//   - FSM state encoding.
//  Sub-module i2c_cmd_fifo
//   - Synchronous FWFT FIFO, parameters WIDTH and DEPTH; ports push, pop, full, empty, level.
//  Top level: FSM, timeout counter and response registers.
// TESTING
//  Bench contains a master model; busy rises 1 cycle after en and stays high for N cycles.
//  1 Write {addr=7'h50, rw=1, mem=5'h03, wdata=8'hA5}, N=30
//    -> single m_en window carrying these values;
//    -> response rdata=8'h00, ack_err=0, timeout=0.
//  2 Read {7'h50, rw=0, mem=5'h1F}, model returns data_rd=8'h3C
//    -> response rdata=8'h3C, ack_err=0.
//  3 Push 5 commands back-to-back with FIFO_DEPTH=4 and master stalled
//    -> cmd_ready=0 after the 4th push;
//    -> 5 responses return in order once the master runs.
//  4 Model never asserts busy
//    -> m_en high for exactly TIMEOUT=16 cycles; response timeout=1;
//    -> next command then issued normally.
//  5 Model sets ack_err=1
//    -> rsp_ack_err=1;
//    -> hold rsp_ready=0 for 10 cycles: no new m_en, response stable.
//  6 Assert rst low while in WAIT
//    -> m_en=0, rsp_valid=0, fifo_level=0, cmd_ready=1 within the same cycle.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared widths, command field offsets and sequencer state encoding
package i2c_pkg;
  localparam int ADDR_W = 7;
  localparam int MEM_W = 5;
  localparam int DATA_W = 8;
  localparam int CMD_W = 21;
  localparam int WD_LSB = 0;
  localparam int MEM_LSB = WD_LSB + DATA_W;
  localparam int RW_LSB = MEM_LSB + MEM_W;
  localparam int ADDR_LSB = RW_LSB + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
endpackage

// File: rtl/i2c_cmd_fifo.sv
// i2c_cmd_fifo: synchronous first-word-fall-through FIFO with occupancy count
module i2c_cmd_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = level == FULL_LVL;
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
endmodule

// File: rtl/i2c_cmd_seq.sv
// i2c_cmd_seq: buffers I2C commands and issues them to the master one at a time,
// returning one response per command in order
module i2c_cmd_seq
  import i2c_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = 16,
  localparam int LW = $clog2(FIFO_DEPTH) + 1,
  localparam int CW = $clog2(TIMEOUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_rw,
  input  logic [MEM_W-1:0]  cmd_mem_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_ack_err,
  output logic              rsp_timeout,
  output logic              m_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_rw,
  output logic [MEM_W-1:0]  m_mem_addr,
  output logic [DATA_W-1:0] m_data_wr,
  input  logic [DATA_W-1:0] m_data_rd,
  input  logic              m_ack_err,
  input  logic              m_busy,
  output logic [LW-1:0]     fifo_level,
  output logic              idle
);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [CMD_W-1:0] head;
  logic empty, full, pop;
  assign cmd_ready = !full;
  assign m_en = state == S_ISSUE;
  assign rsp_valid = state == S_RESP;
  assign idle = empty && state == S_IDLE && !rsp_valid;
  // the command leaves the FIFO once the master takes it or gives up on it
  assign pop = m_en && (m_busy || cnt == CNT_MAX);
  i2c_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk,
    .rst,
    .push(cmd_valid && cmd_ready),
    .pop,
    .din({cmd_addr, cmd_rw, cmd_mem_addr, cmd_wdata}),
    .dout(head),
    .full,
    .empty,
    .level(fifo_level)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      cnt <= '0;
      m_addr <= '0;
      m_rw <= 1'b0;
      m_mem_addr <= '0;
      m_data_wr <= '0;
      rsp_rdata <= '0;
      rsp_ack_err <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (!empty && !m_busy) begin
            state <= S_ISSUE;
            cnt <= '0;
            m_addr <= head[ADDR_LSB +: ADDR_W];
            m_rw <= head[RW_LSB];
            m_mem_addr <= head[MEM_LSB +: MEM_W];
            m_data_wr <= head[WD_LSB +: DATA_W];
          end
        S_ISSUE:
          if (m_busy) begin
            state <= S_WAIT;
            cnt <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= S_RESP;
            rsp_rdata <= '0;
            rsp_ack_err <= 1'b0;
            rsp_timeout <= 1'b1;
          end else cnt <= cnt + 1'b1;
        S_WAIT:
          if (!m_busy) begin
            state <= S_RESP;
            rsp_rdata <= m_rw ? '0 : m_data_rd;
            rsp_ack_err <= m_ack_err;
            rsp_timeout <= 1'b0;
          end
        default:
          if (rsp_ready) state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_i2c_cmd_seq.sv
// tb_i2c_cmd_seq: directed and randomized checks of i2c_cmd_seq against a
// master model and an in-order command/response scoreboard
module tb_i2c_cmd_seq;
  localparam int DEPTH = 4;
  localparam int TO = 16;
  typedef struct packed {logic [6:0] a; logic rw; logic [4:0] m; logic [7:0] d;} cmd_t;
  typedef struct packed {logic [7:0] rd; logic ae; logic to;} rsp_t;
  logic clk = 0, rst = 0;
  logic cmd_valid = 0, cmd_ready, cmd_rw = 0;
  logic [6:0] cmd_addr = 0;
  logic [4:0] cmd_mem_addr = 0;
  logic [7:0] cmd_wdata = 0;
  logic rsp_valid, rsp_ready = 0, rsp_ack_err, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic m_en, m_rw, m_ack_err, m_busy;
  logic [6:0] m_addr;
  logic [4:0] m_mem_addr;
  logic [7:0] m_data_wr, m_data_rd;
  logic [2:0] fifo_level;
  logic idle;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  i2c_cmd_seq #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_mem_addr(cmd_mem_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_ack_err(rsp_ack_err), .rsp_timeout(rsp_timeout),
    .m_en(m_en), .m_addr(m_addr), .m_rw(m_rw), .m_mem_addr(m_mem_addr), .m_data_wr(m_data_wr),
    .m_data_rd(m_data_rd), .m_ack_err(m_ack_err), .m_busy(m_busy),
    .fifo_level(fifo_level), .idle(idle)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // master model: busy rises the cycle after en is seen and lasts n_busy cycles
  int n_busy = 30, bcnt;
  bit never = 0, hold = 0;
  logic [7:0] rd_val = 0;
  logic ack_val = 0, busy_r;
  assign m_busy = busy_r | hold;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      busy_r <= 0;
      bcnt <= 0;
      m_data_rd <= 0;
      m_ack_err <= 0;
    end else if (busy_r) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) busy_r <= 0;
    end else if (m_en && !never) begin
      busy_r <= 1;
      bcnt <= n_busy;
      m_data_rd <= m_rw ? 8'hEE : rd_val;
      m_ack_err <= ack_val;
    end
  // scoreboard: expected issue order and expected responses, from accepted commands
  cmd_t iq[$], cur, pc;
  rsp_t rq[$], er;
  bit tq[$], cur_to;
  int en_len = 0;
  always @(negedge clk)
    if (!rst) begin
      iq.delete();
      tq.delete();
      rq.delete();
      en_len = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        pc = {cmd_addr, cmd_rw, cmd_mem_addr, cmd_wdata};
        iq.push_back(pc);
        tq.push_back(never);
        rq.push_back(never ? rsp_t'{8'h00, 1'b0, 1'b1} : rsp_t'{pc.rw ? 8'h00 : rd_val, ack_val, 1'b0});
      end
      if (m_en) begin
        if (en_len == 0) begin
          if (iq.size() == 0) check("en_unexpected", 1, 0);
          else begin
            cur = iq.pop_front();
            cur_to = tq.pop_front();
          end
        end
        check("m_fields", {m_addr, m_rw, m_mem_addr, m_data_wr}, cur);
        en_len++;
      end else if (en_len != 0) begin
        check("en_len", en_len, cur_to ? TO : 2);
        en_len = 0;
      end
      if (rsp_valid && rsp_ready) begin
        if (rq.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          er = rq.pop_front();
          check("rsp_rdata", rsp_rdata, er.rd);
          check("rsp_ack_err", rsp_ack_err, er.ae);
          check("rsp_timeout", rsp_timeout, er.to);
        end
      end
    end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [6:0] a, input logic rw, input logic [4:0] m, input logic [7:0] d);
    int t = 0;
    cmd_addr = a;
    cmd_rw = rw;
    cmd_mem_addr = m;
    cmd_wdata = d;
    cmd_valid = 1;
    while (!cmd_ready && t < 500) begin
      tick();
      t++;
    end
    if (t >= 500) check("send_timeout", 1, 0);
    tick();
    cmd_valid = 0;
  endtask
  task automatic drain(input bit rnd);
    int t = 0;
    rsp_ready = 1;
    while ((rq.size() != 0 || !idle) && t < 3000) begin
      if (rnd) rsp_ready = 1'($urandom_range(0, 1));
      tick();
      t++;
    end
    rsp_ready = 1;
    check("drain_done", t < 3000, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    cmd_t c;
    int t;
    tick(2);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_m_en", m_en, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_level", fifo_level, 0);
    rst = 1;
    tick(2);
    // single write: m_en rises two cycles after the push
    rsp_ready = 1;
    send(7'h50, 1, 5'h03, 8'hA5);
    check("lat_en_low", m_en, 0);
    tick();
    check("lat_en_high", m_en, 1);
    drain(0);
    rd_val = 8'h3C;
    send(7'h50, 0, 5'h1F, 8'h00);
    drain(0);
    // fill the FIFO while the master holds busy
    hold = 1;
    n_busy = 5;
    rd_val = 8'h96;
    for (int i = 0; i < 4; i++) begin
      check("pre_full_ready", cmd_ready, 1);
      c = cmd_t'($urandom);
      send(c.a, c.rw, c.m, c.d);
    end
    check("full_ready", cmd_ready, 0);
    check("full_level", fifo_level, 4);
    check("full_idle", idle, 0);
    hold = 0;
    c = cmd_t'($urandom);
    send(c.a, c.rw, c.m, c.d);
    drain(0);
    // master never goes busy: timeout, then recovery
    never = 1;
    send(7'h22, 0, 5'h07, 8'h11);
    drain(0);
    never = 0;
    send(7'h23, 0, 5'h08, 8'h12);
    drain(0);
    // ack error with back-pressure on the response port
    ack_val = 1;
    rsp_ready = 0;
    send(7'h31, 1, 5'h02, 8'h5A);
    t = 0;
    while (!rsp_valid && t < 200) begin
      tick();
      t++;
    end
    check("rsp_wait", t < 200, 1);
    ack_val = 0;
    send(7'h32, 0, 5'h04, 8'h00);
    for (int i = 0; i < 10; i++) begin
      check("bp_m_en", m_en, 0);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_ack_err", rsp_ack_err, 1);
      check("bp_rdata", rsp_rdata, 0);
      check("bp_level", fifo_level, 1);
      tick();
    end
    drain(0);
    // reset while the master is busy on a transaction
    n_busy = 20;
    send(7'h40, 0, 5'h10, 8'h00);
    send(7'h41, 1, 5'h11, 8'h77);
    t = 0;
    while (!(busy_r && !m_en) && t < 200) begin
      tick();
      t++;
    end
    check("wait_reached", t < 200, 1);
    rst = 0;
    #1;
    check("arst_m_en", m_en, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_level", fifo_level, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    tick();
    rst = 1;
    tick();
    send(7'h42, 0, 5'h12, 8'h00);
    drain(0);
    // randomized batches
    for (int b = 0; b < 8; b++) begin
      rd_val = 8'($urandom);
      ack_val = 1'($urandom);
      n_busy = $urandom_range(1, 8);
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
        c = cmd_t'($urandom);
        send(c.a, c.rw, c.m, c.d);
      end
      drain(1);
    end
    check("final_rq_empty", rq.size(), 0);
    check("final_iq_empty", iq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
